id_ex_stage: RTL and testbench

- ID/EX pipeline register placed directly upstream of the ALU.
- Captures decoded operands and control from decode and resolves EX/MEM and MEM/WB forwarding at capture time.
- Selects immediate versus register for operand 2.
- Presents registered src1/src2/ctrl to the ALU under a valid/ready handshake, with stall back-pressure and flush.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/id_ex_stage_fwd_mux.sv | 44 ++++
 rtl/id_ex_stage.sv | 117 +++++++++++
 tb/tb_id_ex_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, datapath widths and the hard-wired zero register.
package cpu_pkg;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int IMMW = 16;

  localparam logic [AW-1:0] REG_ZERO = '0;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRLV = 4'b0110;
  localparam logic [3:0] ALU_BEQ  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1000;
  localparam logic [3:0] ALU_ORI  = 4'b1001;
  localparam logic [3:0] ALU_BNE  = 4'b1010;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select for one register read port (EX/MEM beats MEM/WB beats regfile).
// Forwarding is built only when ID_EX_FWD_EN is defined; otherwise the regfile data passes through.
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int DW = cpu_pkg::DW,
  parameter int AW = cpu_pkg::AW
) (
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] reg_data,
  input  logic          exmem_reg_write,
  input  logic [AW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [AW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] data
);

`ifdef ID_EX_FWD_EN
  logic exmem_hit;
  logic memwb_hit;

  // r0 is hard-wired zero, so a pending write to it must never shadow the regfile value
  assign exmem_hit = exmem_reg_write && (exmem_rd != AW'(REG_ZERO)) && (exmem_rd == addr);
  assign memwb_hit = memwb_reg_write && (memwb_rd != AW'(REG_ZERO)) && (memwb_rd == addr);

  always_comb begin
    data = reg_data;
    if (exmem_hit)
      data = exmem_result;
    else if (memwb_hit)
      data = memwb_result;
  end
`else
  logic unused_fwd;

  // Hazards are resolved by stalling upstream, so the pipeline write ports are ignored
  assign unused_fwd = ^{addr, exmem_reg_write, exmem_rd, exmem_result,
                        memwb_reg_write, memwb_rd, memwb_result};
  assign data = reg_data;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with capture-time forwarding and valid/ready flow control.
// Optional macro ID_EX_FWD_EN enables EX/MEM and MEM/WB operand forwarding.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DW   = cpu_pkg::DW,
  parameter int AW   = cpu_pkg::AW,
  parameter int IMMW = cpu_pkg::IMMW
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [DW-1:0]   rs_data_i,
  input  logic [DW-1:0]   rt_data_i,
  input  logic [IMMW-1:0] imm_i,
  input  logic            imm_zext_i,
  input  logic            alu_src_i,
  input  logic [AW-1:0]   rs_addr_i,
  input  logic [AW-1:0]   rt_addr_i,
  input  logic [AW-1:0]   rd_addr_i,
  input  logic [3:0]      alu_ctrl_i,
  input  logic            reg_write_i,
  input  logic            exmem_reg_write_i,
  input  logic [AW-1:0]   exmem_rd_i,
  input  logic [DW-1:0]   exmem_result_i,
  input  logic            memwb_reg_write_i,
  input  logic [AW-1:0]   memwb_rd_i,
  input  logic [DW-1:0]   memwb_result_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [DW-1:0]   src1_o,
  output logic [DW-1:0]   src2_o,
  output logic [3:0]      ctrl_o,
  output logic [AW-1:0]   rd_o,
  output logic            reg_write_o
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state;
  state_t          state_next;
  logic            capture;
  logic [DW-1:0]   rs_fwd;
  logic [DW-1:0]   rt_fwd;
  logic [DW-1:0]   imm_ext;
  logic [DW-1:0]   src2_next;
  logic            reg_write_q;

  fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rs (
    .addr            (rs_addr_i),
    .reg_data        (rs_data_i),
    .exmem_reg_write (exmem_reg_write_i),
    .exmem_rd        (exmem_rd_i),
    .exmem_result    (exmem_result_i),
    .memwb_reg_write (memwb_reg_write_i),
    .memwb_rd        (memwb_rd_i),
    .memwb_result    (memwb_result_i),
    .data            (rs_fwd)
  );

  fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rt (
    .addr            (rt_addr_i),
    .reg_data        (rt_data_i),
    .exmem_reg_write (exmem_reg_write_i),
    .exmem_rd        (exmem_rd_i),
    .exmem_result    (exmem_result_i),
    .memwb_reg_write (memwb_reg_write_i),
    .memwb_rd        (memwb_rd_i),
    .memwb_result    (memwb_result_i),
    .data            (rt_fwd)
  );

  assign out_valid_o = (state == FULL);
  assign in_ready_o  = !out_valid_o || out_ready_i;
  assign capture     = in_valid_i && in_ready_o && !flush_i;

  assign imm_ext   = imm_zext_i ? {{(DW-IMMW){1'b0}}, imm_i}
                                : {{(DW-IMMW){imm_i[IMMW-1]}}, imm_i};
  assign src2_next = alu_src_i ? imm_ext : rt_fwd;

  // Flush wins over everything; a drain empties the stage unless a new entry lands in the same cycle
  always_comb begin
    state_next = state;
    if (flush_i)
      state_next = EMPTY;
    else if (capture)
      state_next = FULL;
    else if (out_ready_i)
      state_next = EMPTY;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= EMPTY;
      src1_o      <= '0;
      src2_o      <= '0;
      ctrl_o      <= '0;
      rd_o        <= '0;
      reg_write_q <= 1'b0;
    end else begin
      state <= state_next;
      if (capture) begin
        src1_o      <= rs_fwd;
        src2_o      <= src2_next;
        ctrl_o      <= alu_ctrl_i;
        rd_o        <= rd_addr_i;
        reg_write_q <= reg_write_i;
      end
    end
  end

  // Payload is left stale after drain/flush, so the writeback enable is qualified here
  assign reg_write_o = reg_write_q && out_valid_o;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations track ID_EX_FWD_EN when it is defined.
module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] rs_data_i;
  logic [31:0] rt_data_i;
  logic [15:0] imm_i;
  logic        imm_zext_i;
  logic        alu_src_i;
  logic [4:0]  rs_addr_i;
  logic [4:0]  rt_addr_i;
  logic [4:0]  rd_addr_i;
  logic [3:0]  alu_ctrl_i;
  logic        reg_write_i;
  logic        exmem_reg_write_i;
  logic [4:0]  exmem_rd_i;
  logic [31:0] exmem_result_i;
  logic        memwb_reg_write_i;
  logic [4:0]  memwb_rd_i;
  logic [31:0] memwb_result_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] src1_o;
  logic [31:0] src2_o;
  logic [3:0]  ctrl_o;
  logic [4:0]  rd_o;
  logic        reg_write_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  id_ex_stage dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .flush_i           (flush_i),
    .in_valid_i        (in_valid_i),
    .in_ready_o        (in_ready_o),
    .rs_data_i         (rs_data_i),
    .rt_data_i         (rt_data_i),
    .imm_i             (imm_i),
    .imm_zext_i        (imm_zext_i),
    .alu_src_i         (alu_src_i),
    .rs_addr_i         (rs_addr_i),
    .rt_addr_i         (rt_addr_i),
    .rd_addr_i         (rd_addr_i),
    .alu_ctrl_i        (alu_ctrl_i),
    .reg_write_i       (reg_write_i),
    .exmem_reg_write_i (exmem_reg_write_i),
    .exmem_rd_i        (exmem_rd_i),
    .exmem_result_i    (exmem_result_i),
    .memwb_reg_write_i (memwb_reg_write_i),
    .memwb_rd_i        (memwb_rd_i),
    .memwb_result_i    (memwb_result_i),
    .out_valid_o       (out_valid_o),
    .out_ready_i       (out_ready_i),
    .src1_o            (src1_o),
    .src2_o            (src2_o),
    .ctrl_o            (ctrl_o),
    .rd_o              (rd_o),
    .reg_write_o       (reg_write_o)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Inputs change 1ns after the edge and outputs are sampled at the same point
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [31:0] exp_fwd;
    rst_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b1; out_ready_i = 1'b1;
    rs_data_i = 32'hAA; rt_data_i = 32'hBB; imm_i = 16'h0; imm_zext_i = 1'b0;
    alu_src_i = 1'b0; rs_addr_i = 5'd1; rt_addr_i = 5'd2; rd_addr_i = 5'd3;
    alu_ctrl_i = 4'b0010; reg_write_i = 1'b1;
    exmem_reg_write_i = 1'b0; exmem_rd_i = 5'd0; exmem_result_i = 32'h0;
    memwb_reg_write_i = 1'b0; memwb_rd_i = 5'd0; memwb_result_i = 32'h0;

    // Reset held for two cycles with a valid instruction present
    tick(); tick();
    check("rst_valid", {31'b0, out_valid_o}, 32'd0);
    check("rst_src1", src1_o, 32'd0);
    check("rst_src2", src2_o, 32'd0);
    check("rst_ctrl", {28'b0, ctrl_o}, 32'd0);
    check("rst_regwr", {31'b0, reg_write_o}, 32'd0);
    rst_i = 1'b1; in_valid_i = 1'b0;
    #1;
    check("rst_ready", {31'b0, in_ready_o}, 32'd1);

    // Basic add
    rs_data_i = 32'd5; rt_data_i = 32'd7; rd_addr_i = 5'd3; in_valid_i = 1'b1;
    tick();
    check("add_valid", {31'b0, out_valid_o}, 32'd1);
    check("add_src1", src1_o, 32'd5);
    check("add_src2", src2_o, 32'd7);
    check("add_ctrl", {28'b0, ctrl_o}, 32'b0010);
    check("add_rd", {27'b0, rd_o}, 32'd3);
    check("add_regwr", {31'b0, reg_write_o}, 32'd1);

    // Forward priority: EX/MEM over MEM/WB over regfile, on both rs and rt
    rs_addr_i = 5'd4; rt_addr_i = 5'd4; rs_data_i = 32'h33; rt_data_i = 32'h44;
    exmem_reg_write_i = 1'b1; exmem_rd_i = 5'd4; exmem_result_i = 32'h11;
    memwb_reg_write_i = 1'b1; memwb_rd_i = 5'd4; memwb_result_i = 32'h22;
    tick();
`ifdef ID_EX_FWD_EN
    exp_fwd = 32'h11;
`else
    exp_fwd = 32'h33;
`endif
    check("fwd_exmem_src1", src1_o, exp_fwd);
`ifdef ID_EX_FWD_EN
    exp_fwd = 32'h11;
`else
    exp_fwd = 32'h44;
`endif
    check("fwd_exmem_src2", src2_o, exp_fwd);
    exmem_rd_i = 5'd0;
    tick();
`ifdef ID_EX_FWD_EN
    exp_fwd = 32'h22;
`else
    exp_fwd = 32'h33;
`endif
    check("fwd_memwb_src1", src1_o, exp_fwd);
`ifdef ID_EX_FWD_EN
    exp_fwd = 32'h22;
`else
    exp_fwd = 32'h44;
`endif
    check("fwd_memwb_src2", src2_o, exp_fwd);

    // r0 is never forwarded
    rs_addr_i = 5'd0; rs_data_i = 32'h55; memwb_rd_i = 5'd0;
    tick();
    check("fwd_r0_src1", src1_o, 32'h55);

    // Immediate path ignores rt forwarding
    rt_addr_i = 5'd4; exmem_rd_i = 5'd4; alu_src_i = 1'b1;
    imm_i = 16'hFFF0; imm_zext_i = 1'b0;
    tick();
    check("imm_sext", src2_o, 32'hFFFF_FFF0);
    imm_zext_i = 1'b1;
    tick();
    check("imm_zext", src2_o, 32'h0000_FFF0);
    imm_i = 16'h1234; imm_zext_i = 1'b0;
    tick();
    check("imm_sext_pos", src2_o, 32'h0000_1234);

    // Known entry, then stall for three cycles with a new instruction waiting
    alu_src_i = 1'b0; rs_addr_i = 5'd6; rt_addr_i = 5'd7;
    rs_data_i = 32'h100; rt_data_i = 32'h200; alu_ctrl_i = 4'b0011; rd_addr_i = 5'd9;
    tick();
    check("pre_stall_src1", src1_o, 32'h100);
    out_ready_i = 1'b0;
    rs_data_i = 32'h300; rt_data_i = 32'h400; alu_ctrl_i = 4'b0100; rd_addr_i = 5'd10;
    #1;
    check("stall_ready", {31'b0, in_ready_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", {31'b0, out_valid_o}, 32'd1);
      check("stall_src1", src1_o, 32'h100);
      check("stall_src2", src2_o, 32'h200);
      check("stall_ctrl", {28'b0, ctrl_o}, 32'b0011);
      check("stall_rd", {27'b0, rd_o}, 32'd9);
      check("stall_ready_hold", {31'b0, in_ready_o}, 32'd0);
    end

    // Release: back-to-back transfer with no bubble
    out_ready_i = 1'b1;
    #1;
    check("release_ready", {31'b0, in_ready_o}, 32'd1);
    tick();
    check("b2b_valid", {31'b0, out_valid_o}, 32'd1);
    check("b2b_src1", src1_o, 32'h300);
    check("b2b_src2", src2_o, 32'h400);
    check("b2b_rd", {27'b0, rd_o}, 32'd10);

    // Drain with no new input: empties, payload held, writeback masked
    in_valid_i = 1'b0;
    tick();
    check("drain_valid", {31'b0, out_valid_o}, 32'd0);
    check("drain_regwr", {31'b0, reg_write_o}, 32'd0);
    check("drain_src1_hold", src1_o, 32'h300);

    // Flush beats a simultaneous capture and drain
    in_valid_i = 1'b1;
    tick();
    check("pre_flush_valid", {31'b0, out_valid_o}, 32'd1);
    flush_i = 1'b1;
    tick();
    check("flush_valid", {31'b0, out_valid_o}, 32'd0);
    check("flush_regwr", {31'b0, reg_write_o}, 32'd0);
    flush_i = 1'b0;

    // Reset while full drops the entry
    tick();
    check("pre_rst_valid", {31'b0, out_valid_o}, 32'd1);
    rst_i = 1'b0;
    tick();
    check("midrst_valid", {31'b0, out_valid_o}, 32'd0);
    check("midrst_src1", src1_o, 32'd0);
    rst_i = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: observed no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
